rx_iq_out_stage: RTL
====================

# rx_iq_out_stage

Output conditioning stage between the DDC decimation chain and the I2S slave transmitter. It takes wide signed I/Q sample pairs from the decimator with a valid strobe and applies a programmable power-of-two gain with round-half-up and saturation to 24 bits. Scaled pairs are buffered in a small pair FIFO, and one coherent pair is presented on the 24-bit `rx_real`/`rx_imag` buses per I2S frame request. Overflow and underrun are counted for host diagnostics.

## Interface
- `IN_W`, 32: decimator sample width, signed two's complement.
- `OUT_W`, 24: output sample width; fixed to match the I2S transmitter.
- `DEPTH`, 4: FIFO depth in I/Q pairs; power of two, 2..16.
- `clock` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `shift` in 3: gain select k, 0..7; gain = 2^k relative to taking the top OUT_W bits.
- `clr` in 1: synchronous clear of `ovf_cnt`, `unf_cnt` and `sat_flag`; FIFO untouched.
- `in_valid` in 1: one-cycle strobe, `in_real`/`in_imag` valid.
- `in_real`, `in_imag` in IN_W: signed decimator outputs.
- `frame_req` in 1: level from the I2S frame marker, already synchronised to `clock`; each rising edge requests one pair.
- `rx_real`, `rx_imag` out OUT_W: held output pair, always updated together.
- `out_strobe` out 1: one-cycle pulse when a new pair is driven.
- `fifo_level` out log2(DEPTH)+1: pairs currently stored.
- `ovf_cnt` out 8: dropped-pair count, saturates at 255.
- `unf_cnt` out 8: empty-on-request count, saturates at 255.
- `sat_flag` out 1: sticky; set when any component clipped.

## Operation
- Scaling: s = (IN_W-OUT_W) - k, with s >= 1 for all legal k.
  - The sum `x + 2^(s-1)` is formed at IN_W+1 bits, then arithmetically shifted right by s.
  - Result is clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Real and imag are scaled independently. Either one clipping sets `sat_flag`.
- `shift` is sampled with the pair in stage 1. A change mid-stream affects only pairs strobed after it.
- Pipeline: stage 1 registers input, round and shift. Stage 2 registers the saturated result and a valid bit. The write to the FIFO happens from stage 2.
- FIFO: circular, with read/write pointers and an extra wrap bit; full/empty are derived from the pointers.
  - Write while full and no read: the pair is dropped and `ovf_cnt`++ (saturating).
  - Write and read in the same cycle: both proceed, with the read first. No drop even when full, and the level is unchanged.
  - Write and read in the same cycle while empty: no bypass. The request is served as an underrun and the written pair is kept.
- Request: rising edge of `frame_req`, detected against a one-cycle delayed copy.
  - Non-empty: pop the head into `rx_real`/`rx_imag` and pulse `out_strobe`.
  - Empty: hold the previous outputs, `unf_cnt`++ (saturating), no `out_strobe`.
- `clr` and an increment in the same cycle: the clear wins.
- Reset mid-operation: the pipeline is flushed, the FIFO is emptied, and outputs return to reset values immediately (asynchronous).

## Timing
- Reset values: `rx_real`=0, `rx_imag`=0, `out_strobe`=0, `fifo_level`=0, `ovf_cnt`=0, `unf_cnt`=0, `sat_flag`=0. Pipeline valids are 0.
- `in_valid` at cycle t: the pair is in the FIFO at the end of t+2. `fifo_level` reflects it at t+3.
- `frame_req` first sampled high at cycle n (low at n-1): the edge is detected at n. `rx_*` and `out_strobe` are valid from n+1. `fifo_level` decrements at n+1.
- Minimum latency from input strobe to output is 4 cycles.
- Input rate: one `in_valid` per cycle is sustained. Back-to-back requests are allowed: `frame_req` toggling each cycle gives one request every 2 cycles.
- `rx_*` remain stable between `out_strobe` pulses. This is required so the I2S transmitter's capture never sees a torn pair.

## Test plan
- Rounding at k=0:
  - `in_real`=0x00000180 -> 0x000002.
  - `in_real`=0x0000017F -> 0x000001.
  - `in_imag`=0xFFFFFE80 -> 0xFFFFFF (-1).
  - Each lands on `rx_*` after one `frame_req` edge, with `out_strobe` pulsing once.
- Saturation at k=7:
  - `in_real`=0x01000000 -> 0x7FFFFF with `sat_flag`=1.
  - `in_imag`=0xFF000000 -> 0x800000 with no clip from the imag side.
  - `clr` drops `sat_flag` to 0.
- Overflow: push 6 pairs with no requests into DEPTH=4 -> `fifo_level`=4, `ovf_cnt`=2. Four requests then return pairs 1..4 in order.
- Underrun: with the FIFO empty after pair value 0x123456/0xABCDEF, issue 3 requests -> outputs hold 0x123456/0xABCDEF, `unf_cnt`=3, no `out_strobe`.
- Simultaneous events:
  - FIFO full, `in_valid` and request edge in the same cycle -> `fifo_level` stays 4, `ovf_cnt` unchanged.
  - FIFO empty, same case -> underrun counted, then `fifo_level`=1.
- Async reset: assert `reset` low mid-stream with 3 pairs stored -> all outputs and counts are 0 within the same cycle. After release, the first request underruns.

Source files
------------

// File: rtl/rx_iq_out_stage_if.sv
// Bus between the DDC output conditioning stage and its surroundings:
// decimator samples in, held I2S pair and diagnostics out.
interface rx_iq_out_stage_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 24,
  parameter int DEPTH = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [2:0]              shift;
  logic                    clr;
  logic                    in_valid;
  logic signed [IN_W-1:0]  in_real;
  logic signed [IN_W-1:0]  in_imag;
  logic                    frame_req;
  logic signed [OUT_W-1:0] rx_real;
  logic signed [OUT_W-1:0] rx_imag;
  logic                    out_strobe;
  logic [LVL_W-1:0]        fifo_level;
  logic [7:0]              ovf_cnt;
  logic [7:0]              unf_cnt;
  logic                    sat_flag;

  modport master (
    output shift, clr, in_valid, in_real, in_imag, frame_req,
    input  rx_real, rx_imag, out_strobe, fifo_level, ovf_cnt, unf_cnt, sat_flag
  );

  modport slave (
    input  shift, clr, in_valid, in_real, in_imag, frame_req,
    output rx_real, rx_imag, out_strobe, fifo_level, ovf_cnt, unf_cnt, sat_flag
  );
endinterface

// File: rtl/rx_iq_out_stage.sv
// Power-of-two gain with round-half-up and saturation, a small I/Q pair FIFO,
// and one coherent pair handed to the I2S transmitter per frame request.
module rx_iq_out_stage #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 24,
  parameter int DEPTH = 4
) (
  input logic clock,
  input logic reset,
  rx_iq_out_stage_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int BASE = IN_W - OUT_W;
  localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [IN_W:0] round_shift(input logic signed [IN_W-1:0] x,
                                                       input logic [2:0] k);
    logic signed [IN_W:0] half;
    logic signed [IN_W:0] sum;
    half = {{IN_W{1'b0}}, 1'b1} << (BASE - 1 - int'(k));
    sum  = {x[IN_W-1], x} + half;
    return sum >>> (BASE - int'(k));
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [IN_W:0] v);
    if (v > SAT_MAX) return SAT_MAX[OUT_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

  function automatic logic clipped(input logic signed [IN_W:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  logic signed [IN_W:0]    re_p1, im_p1;
  logic                    vld_p1;
  logic signed [OUT_W-1:0] re_p2, im_p2;
  logic                    vld_p2;
  logic                    sat;

  logic [AW:0]             wptr, rptr;
  logic [2*OUT_W-1:0]      mem [DEPTH];
  logic                    req_d;
  logic signed [OUT_W-1:0] out_re, out_im;
  logic                    strobe;
  logic [7:0]              ovf, unf;

  logic empty, full, req_edge, do_read, do_write, drop, miss;

  // Stage 1: register the rounded and shifted input at the gain of its own cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) vld_p1 <= 1'b0;
    else        vld_p1 <= bus.in_valid;
  end

  always_ff @(posedge clock) begin
    re_p1 <= round_shift(bus.in_real, bus.shift);
    im_p1 <= round_shift(bus.in_imag, bus.shift);
  end

  // Stage 2: saturated pair ready for the FIFO write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p2 <= 1'b0;
      sat    <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (bus.clr)                                          sat <= 1'b0;
      else if (vld_p1 && (clipped(re_p1) || clipped(im_p1))) sat <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    re_p2 <= saturate(re_p1);
    im_p2 <= saturate(im_p1);
  end

  // FIFO and request handling; a read frees a slot before the same-cycle write
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign req_edge = bus.frame_req & ~req_d;
  assign do_read  = req_edge & ~empty;
  assign miss     = req_edge & empty;
  assign do_write = vld_p2 & (~full | do_read);
  assign drop     = vld_p2 & full & ~do_read;

  always_ff @(posedge clock) begin
    if (do_write) mem[wptr[AW-1:0]] <= {re_p2, im_p2};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr   <= '0;
      rptr   <= '0;
      req_d  <= 1'b0;
      out_re <= '0;
      out_im <= '0;
      strobe <= 1'b0;
      ovf    <= '0;
      unf    <= '0;
    end else begin
      req_d  <= bus.frame_req;
      strobe <= do_read;
      if (do_read) begin
        {out_re, out_im} <= mem[rptr[AW-1:0]];
        rptr             <= rptr + (AW+1)'(1);
      end
      if (do_write) wptr <= wptr + (AW+1)'(1);
      if (bus.clr)                  ovf <= '0;
      else if (drop && ovf != 8'hFF) ovf <= ovf + 8'd1;
      if (bus.clr)                  unf <= '0;
      else if (miss && unf != 8'hFF) unf <= unf + 8'd1;
    end
  end

  assign bus.rx_real    = out_re;
  assign bus.rx_imag    = out_im;
  assign bus.out_strobe = strobe;
  assign bus.fifo_level = wptr - rptr;
  assign bus.ovf_cnt    = ovf;
  assign bus.unf_cnt    = unf;
  assign bus.sat_flag   = sat;
endmodule
